// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU element-wise unit: opcodes, FSM states,
// default geometry and the operand packing helper.
package mpu_pkg;

    localparam int DEF_DIM   = 5;
    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEG  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        STREAM = 2'b10
    } state_e;

    // Bit offset of element [row][col] inside a packed DIMxDIM operand.
    function automatic int elem_lsb(input int row, input int col, input int dim, input int width);
        return (row * dim + col) * width;
    endfunction

endpackage

// File: rtl/mpu_lane_alu.sv
// One combinational element lane: ADD/SUB/NEG/PASS on signed WIDTH-bit values.
// With MPU_SAT_EN defined the lane saturates and flags overflow, otherwise it wraps.
module mpu_lane_alu
    import mpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

`ifdef MPU_SAT_EN
    localparam int EXT_W = WIDTH + 1;
`else
    // Modulo arithmetic: the guard bit could never influence the kept bits.
    localparam int EXT_W = WIDTH;
`endif

    logic signed [EXT_W-1:0] a_ext_s;
    logic signed [EXT_W-1:0] b_ext_s;
    logic signed [EXT_W-1:0] wide_s;

    assign a_ext_s = EXT_W'(signed'(a));
    assign b_ext_s = EXT_W'(signed'(b));

    // Element operation selected by the captured opcode.
    always_comb begin
        wide_s = a_ext_s;
        case (op)
            OP_ADD:  wide_s = a_ext_s + b_ext_s;
            OP_SUB:  wide_s = a_ext_s - b_ext_s;
            OP_NEG:  wide_s = -a_ext_s;
            OP_PASS: wide_s = a_ext_s;
            default: wide_s = a_ext_s;
        endcase
    end

`ifdef MPU_SAT_EN
    // Guard and sign bits disagree exactly when the true result left the range.
    always_comb begin
        ovf = (wide_s[WIDTH] != wide_s[WIDTH-1]);
        if (ovf) begin
            if (wide_s[WIDTH]) begin
                result = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                result = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            result = wide_s[WIDTH-1:0];
        end
    end
`else
    assign result = wide_s;
    assign ovf    = 1'b0;
`endif

endmodule

// File: rtl/mpu_elementwise_unit.sv
// Captures two DIMxDIM matrices plus an opcode and streams the element-wise
// result one row per cycle. Saturation and the overflow flag need MPU_SAT_EN.
module mpu_elementwise_unit
    import mpu_pkg::*;
#(
    parameter int DIM   = DEF_DIM,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [1:0]               op,
    input  logic [DIM*DIM*WIDTH-1:0] matrix_a,
    input  logic [DIM*DIM*WIDTH-1:0] matrix_b,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [DIM*WIDTH-1:0]     row_data,
    output logic [$clog2(DIM)-1:0]   row_index,
    output logic                     row_last,
    output logic                     busy,
    output logic                     overflow
);

    localparam int ROW_W = $clog2(DIM);
    localparam int MAT_W = DIM * DIM * WIDTH;
    localparam int RW    = DIM * WIDTH;

    state_e               state_r;
    state_e               state_next;
    logic [MAT_W-1:0]     a_buf_r;
    logic [MAT_W-1:0]     b_buf_r;
    logic [1:0]           op_r;
    logic [RW-1:0]        row_data_r;
    logic [ROW_W-1:0]     row_index_r;
    logic                 row_valid_r;
    logic                 row_last_r;
    logic                 start_ready_r;
    logic                 busy_r;
    logic                 overflow_r;

    logic                 accept_s;
    logic                 load_row_s;
    logic                 finish_s;
    logic [ROW_W-1:0]     next_row_s;
    logic [RW-1:0]        row_a_s;
    logic [RW-1:0]        row_b_s;
    logic [RW-1:0]        lane_res_s;
    logic [DIM-1:0]       lane_ovf_s;
    logic                 row_ovf_s;

    // Next-state and control decode.
    always_comb begin
        state_next = state_r;
        accept_s   = 1'b0;
        load_row_s = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    accept_s   = 1'b1;
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                load_row_s = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                if (row_valid_r && row_ready) begin
                    if (row_last_r) begin
                        finish_s   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        load_row_s = 1'b1;
                    end
                end else begin
                    state_next = STREAM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Row to compute: row 0 from LOAD, the following row on a STREAM handshake.
    always_comb begin
        if (state_r == LOAD) begin
            next_row_s = {ROW_W{1'b0}};
        end else begin
            next_row_s = row_index_r + ROW_W'(1);
        end
    end

    // Select the operand row feeding the lanes.
    always_comb begin
        row_a_s = {RW{1'b0}};
        row_b_s = {RW{1'b0}};
        for (int r = 0; r < DIM; r++) begin
            if (next_row_s == ROW_W'(r)) begin
                for (int j = 0; j < DIM; j++) begin
                    row_a_s[j*WIDTH +: WIDTH] = a_buf_r[elem_lsb(r, j, DIM, WIDTH) +: WIDTH];
                    row_b_s[j*WIDTH +: WIDTH] = b_buf_r[elem_lsb(r, j, DIM, WIDTH) +: WIDTH];
                end
            end else begin
                row_a_s = row_a_s;
            end
        end
    end

    for (genvar j = 0; j < DIM; j++) begin : g_lane
        mpu_lane_alu #(
            .WIDTH(WIDTH)
        ) u_lane (
            .op     (op_r),
            .a      (row_a_s[j*WIDTH +: WIDTH]),
            .b      (row_b_s[j*WIDTH +: WIDTH]),
            .result (lane_res_s[j*WIDTH +: WIDTH]),
            .ovf    (lane_ovf_s[j])
        );
    end

    assign row_ovf_s = |lane_ovf_s;

    // State, handshake flags and operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            busy_r        <= 1'b0;
            a_buf_r       <= {MAT_W{1'b0}};
            b_buf_r       <= {MAT_W{1'b0}};
            op_r          <= 2'b00;
        end else begin
            state_r       <= state_next;
            start_ready_r <= (state_next == IDLE);
            busy_r        <= (state_next != IDLE);
            if (accept_s) begin
                a_buf_r <= matrix_a;
                b_buf_r <= matrix_b;
                op_r    <= op;
            end
        end
    end

    // Output row register and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_data_r  <= {RW{1'b0}};
            row_index_r <= {ROW_W{1'b0}};
            row_valid_r <= 1'b0;
            row_last_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                overflow_r <= 1'b0;
            end
            if (load_row_s) begin
                row_data_r  <= lane_res_s;
                row_index_r <= next_row_s;
                row_valid_r <= 1'b1;
                row_last_r  <= (next_row_s == ROW_W'(DIM - 1));
                overflow_r  <= overflow_r | row_ovf_s;
            end else if (finish_s) begin
                row_valid_r <= 1'b0;
                row_last_r  <= 1'b0;
            end
        end
    end

    assign start_ready = start_ready_r;
    assign busy        = busy_r;
    assign row_valid   = row_valid_r;
    assign row_data    = row_data_r;
    assign row_index   = row_index_r;
    assign row_last    = row_last_r;
    assign overflow    = overflow_r;

endmodule
